// File: rtl/recovery_csr_restore.sv
// recovery_csr_restore: replays seven backed-up machine CSRs into the core after a recovery event.
// Define RECOVERY_CSR_READBACK_EN to read every CSR back after its write and flag mismatches on error_o.

package recovery_csr_restore_pkg;
  typedef struct packed {
    logic [6:0]  csr_mstatus;
    logic [31:0] csr_mie;
    logic [23:0] csr_mtvec;
    logic [31:0] csr_mscratch;
    logic [31:0] csr_mip;
    logic [31:0] csr_mepc;
    logic [5:0]  csr_mcause;
  } csr_intf_t;
endpackage

module recovery_csr_restore #(
  parameter int  DataWidth     = 32,
  parameter int  TimeoutCycles = 64,
  parameter type csr_intf_t    = recovery_csr_restore_pkg::csr_intf_t
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  output logic                 csr_read_enable_o,
  input  csr_intf_t            recovery_csr_i,
  output logic                 csr_we_o,
  output logic [11:0]          csr_addr_o,
  output logic [DataWidth-1:0] csr_wdata_o,
  input  logic                 csr_gnt_i,
  output logic                 csr_re_o,
  input  logic [DataWidth-1:0] csr_rdata_i,
  input  logic                 csr_rvalid_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 error_o
);

  // state | meaning
  // IDLE  | waiting for start_i
  // LATCH | backup storage read, snapshot captured, error cleared
  // WRITE | CSR write held until granted
  // READ  | readback of the CSR just written (readback build only)
  // DONE  | one-cycle done pulse
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LATCH = 3'd1,
    S_WRITE = 3'd2,
`ifdef RECOVERY_CSR_READBACK_EN
    S_READ  = 3'd3,
`endif
    S_DONE  = 3'd4
  } state_t;

  localparam int TmoW = $clog2(TimeoutCycles + 1);

  state_t               r_state;
  state_t               w_next;
  csr_intf_t            r_csr;
  logic [2:0]           r_idx;
  logic [TmoW-1:0]      r_tmo;
  logic                 r_error;
  logic                 w_tmo_hit;
  logic [11:0]          w_addr;
  logic [DataWidth-1:0] w_exp;

  assign w_tmo_hit = (r_tmo == TmoW'(TimeoutCycles - 1));
  assign error_o   = r_error;

`ifndef RECOVERY_CSR_READBACK_EN
  logic w_unused_rb;
  assign w_unused_rb = ^{csr_rdata_i, csr_rvalid_i};
`endif

  always_comb begin
    w_addr = '0;
    w_exp  = '0;
    case (r_idx)
      3'd0: begin w_addr = 12'h300; w_exp = DataWidth'(r_csr.csr_mstatus);  end
      3'd1: begin w_addr = 12'h304; w_exp = DataWidth'(r_csr.csr_mie);      end
      3'd2: begin w_addr = 12'h305; w_exp = DataWidth'(r_csr.csr_mtvec);    end
      3'd3: begin w_addr = 12'h340; w_exp = DataWidth'(r_csr.csr_mscratch); end
      3'd4: begin w_addr = 12'h344; w_exp = DataWidth'(r_csr.csr_mip);      end
      3'd5: begin w_addr = 12'h341; w_exp = DataWidth'(r_csr.csr_mepc);     end
      3'd6: begin w_addr = 12'h342; w_exp = DataWidth'(r_csr.csr_mcause);   end
      default: ;
    endcase
  end

  always_comb begin
    w_next            = r_state;
    csr_read_enable_o = 1'b0;
    csr_we_o          = 1'b0;
    csr_re_o          = 1'b0;
    csr_addr_o        = '0;
    csr_wdata_o       = '0;
    busy_o            = 1'b1;
    done_o            = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy_o = 1'b0;
        if (start_i) w_next = S_LATCH;
      end
      S_LATCH: begin
        csr_read_enable_o = 1'b1;
        w_next            = S_WRITE;
      end
      S_WRITE: begin
        csr_we_o    = 1'b1;
        csr_addr_o  = w_addr;
        csr_wdata_o = w_exp;
        if (csr_gnt_i) begin
`ifdef RECOVERY_CSR_READBACK_EN
          w_next = S_READ;
`else
          w_next = (r_idx == 3'd6) ? S_DONE : S_WRITE;
`endif
        end else if (w_tmo_hit) begin
          w_next = S_DONE;
        end
      end
`ifdef RECOVERY_CSR_READBACK_EN
      S_READ: begin
        csr_re_o   = 1'b1;
        csr_addr_o = w_addr;
        if (csr_rvalid_i) w_next = (r_idx == 3'd6) ? S_DONE : S_WRITE;
        else if (w_tmo_hit) w_next = S_DONE;
      end
`endif
      S_DONE: begin
        done_o = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_csr   <= '0;
      r_idx   <= '0;
      r_tmo   <= '0;
      r_error <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: if (start_i) r_error <= 1'b0;
        S_LATCH: begin
          r_csr <= recovery_csr_i;
          r_idx <= '0;
          r_tmo <= '0;
        end
        S_WRITE: begin
          if (csr_gnt_i) begin
            r_tmo <= '0;
`ifndef RECOVERY_CSR_READBACK_EN
            r_idx <= r_idx + 3'd1;
`endif
          end else if (w_tmo_hit) begin
            r_error <= 1'b1;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
`ifdef RECOVERY_CSR_READBACK_EN
        S_READ: begin
          if (csr_rvalid_i) begin
            r_tmo <= '0;
            r_idx <= r_idx + 3'd1;
            if (csr_rdata_i != w_exp) r_error <= 1'b1;
          end else if (w_tmo_hit) begin
            r_error <= 1'b1;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
`endif
        default: r_tmo <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_recovery_csr_restore.sv
// Scoreboard bench for recovery_csr_restore: expected CSR writes are queued at start and popped on each grant.
module tb_recovery_csr_restore;
  import recovery_csr_restore_pkg::*;

  localparam int TMO = 64;
`ifdef RECOVERY_CSR_READBACK_EN
  localparam int PER = 2;
`else
  localparam int PER = 1;
`endif
  localparam int LAT_MIN = 2 + 7 * PER;

  logic        clk = 1'b0;
  logic        rst, start, rd_en, we, gnt, re, rvalid, busy, done, err;
  logic [11:0] addr;
  logic [31:0] wdata, rdata;
  csr_intf_t   rcsr;

  always #5 clk = ~clk;

  recovery_csr_restore #(.DataWidth(32), .TimeoutCycles(TMO)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .csr_read_enable_o(rd_en),
    .recovery_csr_i(rcsr), .csr_we_o(we), .csr_addr_o(addr), .csr_wdata_o(wdata),
    .csr_gnt_i(gnt), .csr_re_o(re), .csr_rdata_i(rdata), .csr_rvalid_i(rvalid),
    .busy_o(busy), .done_o(done), .error_o(err)
  );

  typedef struct {logic [11:0] addr; logic [31:0] data;} exp_t;
  exp_t sb[$];
  exp_t mon_e;

  int checks = 0, errors = 0;
  int cyc = 0;
  int done_count = 0, done_cyc = 0, wr_count = 0;
  logic done_err = 1'b0;
  logic [11:0] stall_addr = 12'h000;
  int stall_len = 0, stall_cnt = 0;
  logic [11:0] bad_addr = 12'hFFF;
  logic [31:0] last_wdata = 32'h0;

  always @(posedge clk) cyc <= cyc + 1;

  // Grant/readback responder and scoreboard monitor, all evaluated mid-cycle.
  always @(negedge clk) begin
    if (we && addr == stall_addr && stall_cnt < stall_len) begin
      gnt = 1'b0;
      stall_cnt++;
      if (sb.size() > 0) begin
        checks++;
        if (addr !== sb[0].addr || wdata !== sb[0].data) begin
          errors++;
          $display("FAIL stall_hold got addr=%h data=%h expected addr=%h data=%h", addr, wdata, sb[0].addr, sb[0].data);
        end
      end
    end else begin
      gnt = 1'b1;
    end
    if (we && gnt) begin
      wr_count++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write got addr=%h data=%h expected no write", addr, wdata);
      end else begin
        mon_e = sb.pop_front();
        if (addr !== mon_e.addr || wdata !== mon_e.data) begin
          errors++;
          $display("FAIL write_seq got addr=%h data=%h expected addr=%h data=%h", addr, wdata, mon_e.addr, mon_e.data);
        end
      end
      last_wdata = wdata;
    end
    rvalid = re;
    rdata  = (re && addr !== bad_addr) ? last_wdata : 32'h0;
    if (!we && !re) begin
      checks++;
      if (addr !== 12'h0 || wdata !== 32'h0) begin
        errors++;
        $display("FAIL idle_bus got addr=%h data=%h expected 0/0", addr, wdata);
      end
    end
    if (done) begin
      done_count++;
      done_cyc = cyc;
      done_err = err;
    end
  end

  function automatic logic [11:0] exp_addr(input int i);
    case (i)
      0: return 12'h300;
      1: return 12'h304;
      2: return 12'h305;
      3: return 12'h340;
      4: return 12'h344;
      5: return 12'h341;
      default: return 12'h342;
    endcase
  endfunction

  function automatic logic [31:0] exp_val(input csr_intf_t v, input int i);
    case (i)
      0: return {25'h0, v.csr_mstatus};
      1: return v.csr_mie;
      2: return {8'h0, v.csr_mtvec};
      3: return v.csr_mscratch;
      4: return v.csr_mip;
      5: return v.csr_mepc;
      default: return {26'h0, v.csr_mcause};
    endcase
  endfunction

  function automatic csr_intf_t fixed_vec();
    csr_intf_t v;
    v.csr_mstatus  = 7'h5A;
    v.csr_mie      = 32'h0000_0888;
    v.csr_mtvec    = 24'hABCDEF;
    v.csr_mscratch = 32'hDEAD_BEEF;
    v.csr_mip      = 32'h0000_0080;
    v.csr_mepc     = 32'h8000_1234;
    v.csr_mcause   = 6'h2B;
    return v;
  endfunction

  function automatic csr_intf_t rand_vec();
    csr_intf_t v;
    v.csr_mstatus  = 7'($urandom);
    v.csr_mie      = $urandom;
    v.csr_mtvec    = 24'($urandom);
    v.csr_mscratch = $urandom;
    v.csr_mip      = $urandom | 32'h1;
    v.csr_mepc     = $urandom;
    v.csr_mcause   = 6'($urandom);
    return v;
  endfunction

  task automatic run_restore(input csr_intf_t v, input int n_push, output int lat, output logic e_at_done);
    int d0, st;
    bit ok;
    for (int i = 0; i < n_push; i++) sb.push_back('{exp_addr(i), exp_val(v, i)});
    rcsr = v;
    @(posedge clk); #1;
    start = 1'b1;
    st = cyc;
    d0 = done_count;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rcsr = ~v;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (done_count != d0) begin ok = 1'b1; break; end
      @(posedge clk);
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL done_wait got no done_o expected done within 400 cycles");
    end
    lat = done_cyc - st;
    e_at_done = done_err;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; rcsr = '0; gnt = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({rd_en, we, re, busy, done, err} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b expected 000000", {rd_en, we, re, busy, done, err});
    end
    checks++;
    if (addr !== 12'h0 || wdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_bus got addr=%h data=%h expected 0/0", addr, wdata);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic check_run(input string name, input int lat, input int lat_exp, input logic e, input logic e_exp,
                           input int wr, input int wr_exp);
    checks++;
    if (lat !== lat_exp) begin errors++; $display("FAIL %s_latency got %0d expected %0d", name, lat, lat_exp); end
    checks++;
    if (e !== e_exp) begin errors++; $display("FAIL %s_error got %b expected %b", name, e, e_exp); end
    checks++;
    if (wr !== wr_exp) begin errors++; $display("FAIL %s_writes got %0d expected %0d", name, wr, wr_exp); end
  endtask

  task automatic test_order_data();
    int lat, w0;
    logic e;
    stall_len = 0;
    for (int k = 0; k < 3; k++) begin
      w0 = wr_count;
      run_restore((k == 0) ? fixed_vec() : rand_vec(), 7, lat, e);
      check_run("order", lat, LAT_MIN, e, 1'b0, wr_count - w0, 7);
      checks++;
      if (sb.size() != 0) begin errors++; $display("FAIL order_leftover got %0d expected 0", sb.size()); end
    end
  endtask

  task automatic test_gnt_stall();
    int lat, w0;
    logic e;
    stall_addr = 12'h304; stall_len = 3; stall_cnt = 0;
    w0 = wr_count;
    fork
      run_restore(rand_vec(), 7, lat, e);
      begin
        repeat (4) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
      end
    join
    check_run("stall", lat, LAT_MIN + 3, e, 1'b0, wr_count - w0, 7);
    checks++;
    if (stall_cnt != 3) begin errors++; $display("FAIL stall_count got %0d expected 3", stall_cnt); end
    stall_len = 0;
  endtask

  task automatic test_timeout();
    int lat, w0;
    logic e;
    stall_addr = 12'h340; stall_len = 1000000; stall_cnt = 0;
    w0 = wr_count;
    run_restore(fixed_vec(), 4, lat, e);
    check_run("timeout", lat, 2 + 3 * PER + TMO, e, 1'b1, wr_count - w0, 3);
    checks++;
    if (sb.size() != 1) begin errors++; $display("FAIL timeout_leftover got %0d expected 1", sb.size()); end
    sb.delete();
    stall_len = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL error_sticky got %b expected 1", err); end
    w0 = wr_count;
    run_restore(rand_vec(), 7, lat, e);
    check_run("after_timeout", lat, LAT_MIN, e, 1'b0, wr_count - w0, 7);
  endtask

  task automatic test_reset_mid();
    int lat, w0, d0;
    logic e;
    bit found;
    stall_addr = 12'h341; stall_len = 1000000; stall_cnt = 0;
    for (int i = 0; i < 7; i++) sb.push_back('{exp_addr(i), exp_val(fixed_vec(), i)});
    w0 = wr_count;
    rcsr = fixed_vec();
    @(posedge clk); #1 start = 1'b1;
    d0 = done_count;
    @(posedge clk); #1 start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (we && addr == 12'h341) begin found = 1'b1; break; end
    end
    checks++;
    if (!found) begin errors++; $display("FAIL mepc_wait got no mepc write expected one"); end
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({rd_en, we, re, busy, done, err} !== 6'b0 || addr !== 12'h0 || wdata !== 32'h0) begin
      errors++;
      $display("FAIL midreset_outputs got ctrl=%b addr=%h data=%h expected all 0",
               {rd_en, we, re, busy, done, err}, addr, wdata);
    end
    @(posedge clk); #1 rst = 1'b0;
    stall_len = 0;
    repeat (10) @(posedge clk);
    checks++;
    if (done_count != d0) begin errors++; $display("FAIL midreset_done got %0d pulses expected 0", done_count - d0); end
    checks++;
    if (wr_count - w0 != 5) begin errors++; $display("FAIL midreset_writes got %0d expected 5", wr_count - w0); end
    sb.delete();
    w0 = wr_count;
    run_restore(rand_vec(), 7, lat, e);
    check_run("after_reset", lat, LAT_MIN, e, 1'b0, wr_count - w0, 7);
  endtask

`ifdef RECOVERY_CSR_READBACK_EN
  task automatic test_readback();
    int lat, w0;
    logic e;
    stall_len = 0;
    bad_addr = 12'h344;
    w0 = wr_count;
    run_restore(fixed_vec(), 7, lat, e);
    check_run("readback", lat, LAT_MIN, e, 1'b1, wr_count - w0, 7);
    bad_addr = 12'hFFF;
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog got no completion expected finish before 2ms");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_order_data();
    test_gnt_stall();
    test_timeout();
    test_reset_mid();
`ifdef RECOVERY_CSR_READBACK_EN
    test_readback();
`endif
    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
